// File: rtl/uop_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : uop_sequencer                                            |
// | Description : Microprogram sequencer for the curve arithmetic core.    |
// |               Walks an external synchronous uop ROM from a selectable  |
// |               start address and issues each uop to the field-arithmetic|
// |               execution unit over a valid/ready/done handshake.        |
// |               Conditional uops are skipped against flags latched when  |
// |               a CMP uop completes. A program ends normally on the RDY  |
// |               opcode, or with an error when it runs past the last      |
// |               ROM address.                                             |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
// | Ports                                                                  |
// |   clk, rst_n          clock, asynchronous active-low reset             |
// |   start, start_addr   run request (honoured only when rdy) + first addr |
// |   rdy, done, err      idle flag, normal-end pulse, abnormal-end pulse  |
// |   rom_addr, rom_data  registered ROM address, word one cycle later     |
// |   uop_valid/ready     issue handshake to the execution unit            |
// |   uop_done            completion pulse of the accepted uop             |
// |   uop_opcode/src1/src2/dst  issued uop fields (held while not valid)   |
// |   cmp_flags, flags    compare result input, latched flag register      |
// +------------------------------------------------------------------------+
module uop_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int OPCODE_W = 4,
  parameter int SRC_W    = 4,
  parameter int DST_W    = 4,
  parameter int EXEC_W   = 4,
  parameter int OPC_RDY  = 0,
  parameter int OPC_CMP  = 1,
  localparam int FLAG_W  = EXEC_W / 2,
  localparam int UOP_W   = OPCODE_W + 2*SRC_W + DST_W + EXEC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  output logic                rdy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [UOP_W-1:0]    rom_data,
  output logic                uop_valid,
  input  logic                uop_ready,
  input  logic                uop_done,
  output logic [OPCODE_W-1:0] uop_opcode,
  output logic [SRC_W-1:0]    uop_src1,
  output logic [SRC_W-1:0]    uop_src2,
  output logic [DST_W-1:0]    uop_dst,
  input  logic [FLAG_W-1:0]   cmp_flags,
  output logic [FLAG_W-1:0]   flags
);

  localparam logic [OPCODE_W-1:0] c_opc_rdy = OPCODE_W'(OPC_RDY);
  localparam logic [OPCODE_W-1:0] c_opc_cmp = OPCODE_W'(OPC_CMP);
  localparam logic [ADDR_W-1:0]   c_one     = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  // Registered state
  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    r_rom_addr;
  logic [FLAG_W-1:0]    r_flags;
  logic [OPCODE_W-1:0]  r_opcode;
  logic [SRC_W-1:0]     r_src1;
  logic [SRC_W-1:0]     r_src2;
  logic [DST_W-1:0]     r_dst;
  logic                 r_valid;
  logic                 r_rdy;
  logic                 r_done;
  logic                 r_err;

  // Next-state values
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    w_pc_nxt;
  logic [ADDR_W-1:0]    w_rom_addr_nxt;
  logic [FLAG_W-1:0]    w_flags_nxt;
  logic [OPCODE_W-1:0]  w_opcode_nxt;
  logic [SRC_W-1:0]     w_src1_nxt;
  logic [SRC_W-1:0]     w_src2_nxt;
  logic [DST_W-1:0]     w_dst_nxt;
  logic                 w_valid_nxt;
  logic                 w_rdy_nxt;
  logic                 w_done_nxt;
  logic                 w_err_nxt;

  // ROM word split MSB-first: opcode | src1 | src2 | dst | exec
  logic [OPCODE_W-1:0]  w_opcode;
  logic [SRC_W-1:0]     w_src1;
  logic [SRC_W-1:0]     w_src2;
  logic [DST_W-1:0]     w_dst;
  logic [FLAG_W-1:0]    w_mask;
  logic [FLAG_W-1:0]    w_match;
  logic                 w_cond;
  logic                 w_pc_last;

  assign w_opcode = rom_data[UOP_W-1 -: OPCODE_W];
  assign w_src1   = rom_data[UOP_W-OPCODE_W-1 -: SRC_W];
  assign w_src2   = rom_data[UOP_W-OPCODE_W-SRC_W-1 -: SRC_W];
  assign w_dst    = rom_data[EXEC_W+DST_W-1 -: DST_W];
  assign w_mask   = rom_data[EXEC_W-1 -: FLAG_W];
  assign w_match  = rom_data[FLAG_W-1:0];

  // Only the flag bits selected by the mask take part; mask=0 always executes.
  assign w_cond    = ((r_flags & w_mask) == (w_match & w_mask));
  // pc never wraps: leaving the last address without RDY is an error end.
  assign w_pc_last = &r_pc;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_rom_addr_nxt = r_rom_addr;
    w_flags_nxt    = r_flags;
    w_opcode_nxt   = r_opcode;
    w_src1_nxt     = r_src1;
    w_src2_nxt     = r_src2;
    w_dst_nxt      = r_dst;
    w_valid_nxt    = r_valid;
    w_rdy_nxt      = r_rdy;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pc_nxt       = start_addr;
          w_rom_addr_nxt = start_addr;
          w_flags_nxt    = '0;
          w_rdy_nxt      = 1'b0;
          w_state_nxt    = S_FETCH;
        end
      end

      // ROM latency slot: rom_data for rom_addr appears next cycle.
      S_FETCH: begin
        w_state_nxt = S_DECODE;
      end

      S_DECODE: begin
        if (w_opcode == c_opc_rdy) begin
          w_done_nxt  = 1'b1;
          w_rdy_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_cond) begin
          w_opcode_nxt = w_opcode;
          w_src1_nxt   = w_src1;
          w_src2_nxt   = w_src2;
          w_dst_nxt    = w_dst;
          w_valid_nxt  = 1'b1;
          w_state_nxt  = S_ISSUE;
        end else if (w_pc_last) begin
          w_err_nxt   = 1'b1;
          w_rdy_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_pc_nxt       = r_pc + c_one;
          w_rom_addr_nxt = r_pc + c_one;
          w_state_nxt    = S_FETCH;
        end
      end

      S_ISSUE: begin
        if (uop_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (uop_done) begin
          if (r_opcode == c_opc_cmp) begin
            w_flags_nxt = cmp_flags;
          end
          if (w_pc_last) begin
            w_err_nxt   = 1'b1;
            w_rdy_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_pc_nxt       = r_pc + c_one;
            w_rom_addr_nxt = r_pc + c_one;
            w_state_nxt    = S_FETCH;
          end
        end
      end

      default: begin
        w_valid_nxt = 1'b0;
        w_rdy_nxt   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_rom_addr <= '0;
      r_flags    <= '0;
      r_opcode   <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_dst      <= '0;
      r_valid    <= 1'b0;
      r_rdy      <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_flags    <= w_flags_nxt;
      r_opcode   <= w_opcode_nxt;
      r_src1     <= w_src1_nxt;
      r_src2     <= w_src2_nxt;
      r_dst      <= w_dst_nxt;
      r_valid    <= w_valid_nxt;
      r_rdy      <= w_rdy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign rdy        = r_rdy;
  assign done       = r_done;
  assign err        = r_err;
  assign rom_addr   = r_rom_addr;
  assign uop_valid  = r_valid;
  assign uop_opcode = r_opcode;
  assign uop_src1   = r_src1;
  assign uop_src2   = r_src2;
  assign uop_dst    = r_dst;
  assign flags      = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_uop_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_uop_sequencer                                         |
// | Description : Self-checking bench for uop_sequencer. A ROM model and   |
// |               an execution-unit model surround the DUT; expected issued|
// |               uops are queued when a program is started and a monitor  |
// |               pops and compares them on every acceptance.              |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_uop_sequencer;

  localparam int ADDR_W = 6;
  localparam int UOP_W  = 20;
  localparam int FLAG_W = 2;

  localparam logic [3:0] OP_RDY = 4'd0;
  localparam logic [3:0] OP_CMP = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_MOV = 4'd5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              rdy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] rom_addr;
  logic [UOP_W-1:0]  rom_data = '0;
  logic              uop_valid;
  logic              uop_ready = 1'b1;
  logic              uop_done = 1'b0;
  logic [3:0]        uop_opcode;
  logic [3:0]        uop_src1;
  logic [3:0]        uop_src2;
  logic [3:0]        uop_dst;
  logic [FLAG_W-1:0] cmp_flags = 2'b11;
  logic [FLAG_W-1:0] flags;

  always #5 clk = ~clk;

  uop_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .rdy        (rdy),
    .done       (done),
    .err        (err),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .uop_valid  (uop_valid),
    .uop_ready  (uop_ready),
    .uop_done   (uop_done),
    .uop_opcode (uop_opcode),
    .uop_src1   (uop_src1),
    .uop_src2   (uop_src2),
    .uop_dst    (uop_dst),
    .cmp_flags  (cmp_flags),
    .flags      (flags)
  );

  // Synchronous ROM
  logic [UOP_W-1:0] rom [64];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q [$];
  int acc_cnt  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  // Execution-unit configuration, set by the stimulus; gen marks a new test.
  int gen        = 0;
  int stall_req  = 0;
  int done_req   = 1000;
  bit noise_req  = 1'b0;
  bit acc_q      = 1'b0;

  function automatic logic [UOP_W-1:0] mk(input logic [3:0] op, input logic [3:0] s1,
                                          input logic [3:0] s2, input logic [3:0] d,
                                          input logic [3:0] ex);
    return {op, s1, s2, d, ex};
  endfunction

  function automatic logic [15:0] fld(input logic [3:0] op, input logic [3:0] s1,
                                      input logic [3:0] s2, input logic [3:0] d);
    return {op, s1, s2, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Acceptance seen mid-cycle happens at the next rising edge.
  always @(negedge clk) acc_q = rst_n && uop_valid && uop_ready;

  // Execution-unit model: done one cycle after acceptance, optional stall
  // of the first issued uop, optional stray done while a uop is still in ISSUE.
  int seen_gen = 0;
  int stalled  = 0;
  int dones    = 0;
  bit noise_used = 1'b0;
  always @(posedge clk) begin
    #2;
    if (gen != seen_gen) begin
      seen_gen   = gen;
      stalled    = 0;
      dones      = 0;
      noise_used = 1'b0;
    end
    if (!rst_n) begin
      uop_done  = 1'b0;
      uop_ready = 1'b1;
    end else begin
      uop_done = 1'b0;
      if (acc_q && dones < done_req) begin
        uop_done = 1'b1;
        dones++;
      end
      if (stalled < stall_req && uop_valid) begin
        uop_ready = 1'b0;
        stalled++;
      end else begin
        uop_ready = 1'b1;
      end
      if (noise_req && !noise_used && uop_valid && !uop_ready) begin
        uop_done   = 1'b1;
        noise_used = 1'b1;
      end
    end
  end

  // Monitor: compares each accepted uop against the scoreboard and checks
  // that fields stay stable while a uop is held under backpressure.
  bit          p_valid = 1'b0;
  bit          p_acc   = 1'b0;
  logic [15:0] p_fields = '0;
  always @(negedge clk) begin
    logic [15:0] cur;
    logic [15:0] e;
    cur = {uop_opcode, uop_src1, uop_src2, uop_dst};
    if (rst_n) begin
      if (uop_valid && p_valid && !p_acc)
        check("hold_fields", {16'h0, cur}, {16'h0, p_fields});
      if (uop_valid && uop_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_issue: got 0x%0h, expected no issue", cur);
        end else begin
          e = exp_q.pop_front();
          check("issue_fields", {16'h0, cur}, {16'h0, e});
        end
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
    p_valid  = uop_valid;
    p_acc    = uop_valid && uop_ready;
    p_fields = cur;
  end

  // Start a program and count negedges until done/err; lat=0 means timeout.
  // With poke set, a second start is pulsed while the sequencer is busy.
  task automatic run_prog(input logic [ADDR_W-1:0] sa, input bit poke, input int limit,
                          output int lat, output bit got_done, output bit got_err);
    int w;
    lat = 0; got_done = 1'b0; got_err = 1'b0;
    w = 0;
    while (!rdy && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    start = 1'b1; start_addr = sa;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (poke && k == 3) begin start = 1'b1; start_addr = '0; end
      if (poke && k == 4) start = 1'b0;
      if (done || err) begin
        lat = k; got_done = done; got_err = err;
        break;
      end
    end
    start = 1'b0;
    if (lat == 0) begin
      n_checks++;
      $display("FAIL timeout: got no done/err after %0d cycles, expected an end pulse", limit);
    end
  endtask

  task automatic end_checks(input string tag, input int lat, input int exp_lat,
                            input bit gd, input bit ge, input bit exp_d, input bit exp_e,
                            input int acc0, input int exp_acc);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done"}, {31'h0, gd}, {31'h0, exp_d});
    check({tag, "_err"}, {31'h0, ge}, {31'h0, exp_e});
    check({tag, "_issues"}, acc_cnt - acc0, exp_acc);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    check({tag, "_rdy"}, {31'h0, rdy}, 32'h1);
    check({tag, "_pulse_low"}, {30'h0, done, err}, 32'h0);
  endtask

  initial begin
    int  lat;
    bit  gd, ge;
    int  acc0, d0, e0, w;

    for (int i = 0; i < 64; i++) rom[i] = '0;
    // Straight program at 0
    rom[0]  = mk(OP_ADD, 4'd1, 4'd2, 4'd3, 4'h0);
    rom[1]  = mk(OP_MUL, 4'd3, 4'd4, 4'd5, 4'h0);
    rom[2]  = mk(OP_SUB, 4'd5, 4'd6, 4'd7, 4'h0);
    rom[3]  = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 4'h0);
    // Noise program at 8
    rom[8]  = mk(OP_ADD, 4'd8, 4'd9, 4'd10, 4'h0);
    rom[9]  = mk(OP_SUB, 4'd11, 4'd12, 4'd13, 4'h0);
    rom[10] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 4'h0);
    // Conditional program at 24; RDY carries a nonzero exec that must be ignored
    rom[24] = mk(OP_CMP, 4'd1, 4'd2, 4'd0, 4'h0);
    rom[25] = mk(OP_MOV, 4'd1, 4'd0, 4'd2, 4'b0101);
    rom[26] = mk(OP_MOV, 4'd2, 4'd0, 4'd3, 4'b0101);
    rom[27] = mk(OP_MOV, 4'd3, 4'd0, 4'd4, 4'b0101);
    rom[28] = mk(OP_MOV, 4'd4, 4'd0, 4'd5, 4'b0100);
    rom[29] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 4'hF);
    // Backpressure program at 40
    rom[40] = mk(OP_MUL, 4'd14, 4'd15, 4'd1, 4'h0);
    rom[41] = mk(OP_RDY, 4'd0, 4'd0, 4'd0, 4'h0);
    // Missing terminator at the top of the address space
    rom[62] = mk(OP_ADD, 4'd6, 4'd7, 4'd8, 4'h0);
    rom[63] = mk(OP_MUL, 4'd9, 4'd10, 4'd11, 4'h0);

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rdy", {31'h0, rdy}, 32'h1);
    check("rst_done_err_valid", {29'h0, done, err, uop_valid}, 32'h0);
    check("rst_rom_addr", {26'h0, rom_addr}, 32'h0);
    check("rst_fields", {16'h0, uop_opcode, uop_src1, uop_src2, uop_dst}, 32'h0);
    check("rst_flags", {30'h0, flags}, 32'h0);
    rst_n = 1'b1;

    // Straight program: 3 uops x 4 cycles, then FETCH+DECODE of RDY; done
    // registered at the 14th edge after the edge that samples start.
    gen++; cmp_flags = 2'b11;
    acc0 = acc_cnt;
    exp_q.push_back(fld(OP_ADD, 4'd1, 4'd2, 4'd3));
    exp_q.push_back(fld(OP_MUL, 4'd3, 4'd4, 4'd5));
    exp_q.push_back(fld(OP_SUB, 4'd5, 4'd6, 4'd7));
    run_prog(6'd0, 1'b0, 200, lat, gd, ge);
    end_checks("straight", lat, 14, gd, ge, 1'b1, 1'b0, acc0, 3);
    check("straight_flags_no_cmp", {30'h0, flags}, 32'h0);

    // Conditional: CMP + 3 MOVs executed (16), one skip (2), RDY (2) = 20
    gen++; cmp_flags = 2'b01;
    acc0 = acc_cnt;
    exp_q.push_back(fld(OP_CMP, 4'd1, 4'd2, 4'd0));
    exp_q.push_back(fld(OP_MOV, 4'd1, 4'd0, 4'd2));
    exp_q.push_back(fld(OP_MOV, 4'd2, 4'd0, 4'd3));
    exp_q.push_back(fld(OP_MOV, 4'd3, 4'd0, 4'd4));
    run_prog(6'd24, 1'b0, 200, lat, gd, ge);
    end_checks("cond", lat, 20, gd, ge, 1'b1, 1'b0, acc0, 4);
    check("cond_flags", {30'h0, flags}, 32'h1);

    // Backpressure: 5 stall cycles on top of 4 + 2
    gen++; cmp_flags = 2'b11; stall_req = 5;
    acc0 = acc_cnt;
    exp_q.push_back(fld(OP_MUL, 4'd14, 4'd15, 4'd1));
    run_prog(6'd40, 1'b0, 200, lat, gd, ge);
    check("bp_flags_cleared", {30'h0, flags}, 32'h0);
    end_checks("bp", lat, 11, gd, ge, 1'b1, 1'b0, acc0, 1);
    stall_req = 0;

    // Missing terminator: error raised as the uop at 63 completes
    gen++;
    acc0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(fld(OP_ADD, 4'd6, 4'd7, 4'd8));
    exp_q.push_back(fld(OP_MUL, 4'd9, 4'd10, 4'd11));
    run_prog(6'd62, 1'b0, 200, lat, gd, ge);
    end_checks("noterm", lat, 8, gd, ge, 1'b0, 1'b1, acc0, 2);
    check("noterm_done_count", done_cnt - d0, 0);
    check("noterm_err_count", err_cnt - e0, 1);

    // Protocol noise: stray done in ISSUE, start while busy, 3 stall cycles
    gen++; stall_req = 3; noise_req = 1'b1;
    acc0 = acc_cnt;
    exp_q.push_back(fld(OP_ADD, 4'd8, 4'd9, 4'd10));
    exp_q.push_back(fld(OP_SUB, 4'd11, 4'd12, 4'd13));
    run_prog(6'd8, 1'b1, 200, lat, gd, ge);
    end_checks("noise", lat, 13, gd, ge, 1'b1, 1'b0, acc0, 2);
    stall_req = 0; noise_req = 1'b0;

    // Reset during WAIT of the second uop (its done is withheld)
    gen++; done_req = 1;
    acc0 = acc_cnt; d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back(fld(OP_ADD, 4'd1, 4'd2, 4'd3));
    exp_q.push_back(fld(OP_MUL, 4'd3, 4'd4, 4'd5));
    @(negedge clk);
    start = 1'b1; start_addr = 6'd0;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (acc_cnt < acc0 + 2 && w < 100) begin @(negedge clk); w++; end
    check("rstmid_issues", acc_cnt - acc0, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstmid_rdy", {31'h0, rdy}, 32'h1);
    check("rstmid_done_err_valid", {29'h0, done, err, uop_valid}, 32'h0);
    check("rstmid_rom_addr", {26'h0, rom_addr}, 32'h0);
    check("rstmid_fields", {16'h0, uop_opcode, uop_src1, uop_src2, uop_dst}, 32'h0);
    check("rstmid_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gen++; done_req = 1000;
    check("rstmid_no_end_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    acc0 = acc_cnt;
    exp_q.push_back(fld(OP_ADD, 4'd1, 4'd2, 4'd3));
    exp_q.push_back(fld(OP_MUL, 4'd3, 4'd4, 4'd5));
    exp_q.push_back(fld(OP_SUB, 4'd5, 4'd6, 4'd7));
    run_prog(6'd0, 1'b0, 200, lat, gd, ge);
    end_checks("after_rst", lat, 14, gd, ge, 1'b1, 1'b0, acc0, 3);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
